// File: rtl/main_memory.sv
// Word-organised main memory behind the L1 miss/writeback port, with a boot loader
// that packs a little-endian byte stream into 64-bit words and holds the CPU in reset.
module main_memory #(
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter logic [60:0] BASE_WORD  = 61'h2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [60:0]           l1_to_mem__addr,
    input  logic [63:0]           l1_to_mem__wr_data,
    output logic [63:0]           l1_to_mem__rd_data,
    input  logic                  l1_to_mem__en,
    input  logic                  l1_to_mem__we,
    input  logic                  ld__valid,
    output logic                  ld__ready,
    input  logic [7:0]            ld__data,
    input  logic                  ld__last,
    output logic [DEPTH_LOG2:0]   ld__words,
    output logic                  cpu_rst,
    output logic                  mem_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q;
    logic [2:0]            byte_cnt_q, byte_cnt_d;
    logic [63:0]           pack_q, pack_d;
    logic [63:0]           ld_word;
    logic [DEPTH_LOG2:0]   words_q, words_d;
    logic                  err_q, err_d;
    logic [63:0]           rd_q;

    logic [63:0]           mem [DEPTH];

    logic                  ld_fire;
    logic                  ld_flush;
    logic                  ld_full;
    logic [60:0]           offset;
    logic                  in_range;
    logic                  run_rd;
    logic                  run_wr;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [63:0]           ram_wdata;

    // ready_q is only ever set while in LOAD, so it also qualifies the state.
    assign ld_fire  = ld__valid && ready_q;
    assign ld_flush = ld_fire && ((byte_cnt_q == 3'd7) || ld__last);
    // The word counter saturates at exactly DEPTH, so its MSB means "full".
    assign ld_full  = words_q[DEPTH_LOG2];

    assign offset   = l1_to_mem__addr - BASE_WORD;
    assign in_range = ((offset >> DEPTH_LOG2) == '0);
    assign run_rd   = (state_q == RUN) && l1_to_mem__en && !l1_to_mem__we;
    assign run_wr   = (state_q == RUN) && l1_to_mem__en &&  l1_to_mem__we;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        ld_word                      = pack_q;
        ld_word[8*byte_cnt_q +: 8]   = ld__data;

        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        if (ld_fire) begin
            if (ld_flush) begin
                pack_d     = '0;
                byte_cnt_d = 3'd0;
                if (!ld_full) begin
                    words_d = words_q + 1'b1;
                end
            end else begin
                pack_d     = ld_word;
                byte_cnt_d = byte_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (ld_flush && ld_full) begin
            err_d = 1'b1;
        end
        if ((run_rd || run_wr) && !in_range) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (ld_fire && ld__last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = LOAD;
        endcase
    end

    // Single RAM port shared between the loader (LOAD) and the L1 port (RUN).
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = offset[DEPTH_LOG2-1:0];
        ram_wdata = l1_to_mem__wr_data;
        if (state_q == LOAD) begin
            ram_we    = ld_flush && !ld_full;
            ram_addr  = words_q[DEPTH_LOG2-1:0];
            ram_wdata = ld_word;
        end else begin
            ram_we    = run_wr && in_range;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD;
            ready_q    <= 1'b0;
            byte_cnt_q <= 3'd0;
            pack_q     <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == LOAD);
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            words_q    <= words_d;
            err_q      <= err_d;
            if (run_rd) begin
                rd_q <= in_range ? mem[ram_addr] : 64'd0;
            end
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and start undefined.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    assign l1_to_mem__rd_data = rd_q;
    assign ld__ready          = ready_q;
    assign ld__words          = words_q;
    assign cpu_rst            = (state_q == LOAD);
    assign mem_err            = err_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: directed boot/run scenarios plus randomized loads and L1
// traffic checked against a byte-stream/word-array model of the memory.
module tb_main_memory;

    localparam logic [60:0] BASE = 61'h2000;
    localparam int unsigned DL   = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic [60:0] addr  = '0;
    logic [63:0] wdata = '0;
    logic        en    = 1'b0;
    logic        we    = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data  = '0;
    logic        last  = 1'b0;
    logic [63:0] rd_data;
    logic        ready;
    logic [DL:0] words;
    logic        cpu_rst;
    logic        err;

    logic [60:0] s_addr  = '0;
    logic [63:0] s_wdata = '0;
    logic        s_en    = 1'b0;
    logic        s_we    = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = '0;
    logic        s_last  = 1'b0;
    logic [63:0] s_rd_data;
    logic        s_ready;
    logic [2:0]  s_words;
    logic        s_cpu_rst;
    logic        s_err;

    main_memory dut (
        .clk(clk), .rst(rst),
        .l1_to_mem__addr(addr), .l1_to_mem__wr_data(wdata), .l1_to_mem__rd_data(rd_data),
        .l1_to_mem__en(en), .l1_to_mem__we(we),
        .ld__valid(valid), .ld__ready(ready), .ld__data(data), .ld__last(last),
        .ld__words(words), .cpu_rst(cpu_rst), .mem_err(err)
    );

    main_memory #(.DEPTH_LOG2(2)) dut_small (
        .clk(clk), .rst(rst),
        .l1_to_mem__addr(s_addr), .l1_to_mem__wr_data(s_wdata), .l1_to_mem__rd_data(s_rd_data),
        .l1_to_mem__en(s_en), .l1_to_mem__we(s_we),
        .ld__valid(s_valid), .ld__ready(s_ready), .ld__data(s_data), .ld__last(s_last),
        .ld__words(s_words), .cpu_rst(s_cpu_rst), .mem_err(s_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0]  model_mem [int];
    logic [63:0]  exp_rd;
    logic         exp_err;
    int           exp_words;
    byte unsigned img[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset is asserted between edges so the checks below see its asynchronous effect.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; valid = 1'b0; last = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        #2;
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_ready",   64'(ready),   64'd0);
        check("rst_words",   64'(words),   64'd0);
        check("rst_err",     64'(err),     64'd0);
        check("rst_rd_data", rd_data,      64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready), 64'd1);
        exp_rd = '0; exp_err = 1'b0; exp_words = 0;
    endtask

    // Streams img[] into the big instance; the model packs it into words by byte index.
    task automatic load_image(input bit gaps);
        int n;
        n = img.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                valid = 1'b0;
                last  = 1'b0;
            end
            @(negedge clk);
            check("ld_ready_during_load", 64'(ready), 64'd1);
            valid = 1'b1;
            data  = img[i];
            last  = (i == n - 1);
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        for (int k = 0; k < (n + 7) / 8; k++) begin
            logic [63:0] w;
            w = '0;
            for (int b = 0; b < 8; b++) begin
                if (8 * k + b < n) w = w | (64'(img[8 * k + b]) << (8 * b));
            end
            model_mem[k] = w;
        end
        exp_words = (n + 7) / 8;
        check("ld_words",     64'(words),   64'(exp_words));
        check("cpu_rst_low",  64'(cpu_rst), 64'd0);
        check("ready_in_run", 64'(ready),   64'd0);
    endtask

    task automatic access(input logic is_wr, input logic [60:0] a, input logic [63:0] d);
        logic [60:0] off;
        bit          inr;
        @(negedge clk);
        en = 1'b1; we = is_wr; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; we = 1'b0;
        off = a - BASE;
        inr = (off < 61'(64'd1 << DL));
        if (is_wr) begin
            if (inr) model_mem[int'(off)] = d;
            else     exp_err = 1'b1;
        end else begin
            if (inr) exp_rd = model_mem.exists(int'(off)) ? model_mem[int'(off)] : 64'd0;
            else begin
                exp_rd  = 64'd0;
                exp_err = 1'b1;
            end
        end
        check($sformatf("%s_%h_rd_data", is_wr ? "wr" : "rd", a), rd_data, exp_rd);
        check($sformatf("%s_%h_mem_err", is_wr ? "wr" : "rd", a), 64'(err), 64'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r64;
        int          op;
        int          n;

        do_reset();

        // Small instance: 40 bytes into a 4-word array, no last byte.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'(i);
            if (i == 32) begin
                check("small_words_at_full", 64'(s_words), 64'd4);
                check("small_err_at_full",   64'(s_err),   64'd0);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("small_ready",   64'(s_ready),   64'd1);
        check("small_words",   64'(s_words),   64'd4);
        check("small_err",     64'(s_err),     64'd1);
        check("small_cpu_rst", 64'(s_cpu_rst), 64'd1);

        // 16 sequential bytes: last lands on a full 8th byte.
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'(i));
        load_image(1'b0);
        access(1'b0, 61'h2000, '0);
        check("seq_word0", rd_data, 64'h0706050403020100);
        access(1'b0, 61'h2001, '0);
        check("seq_word1", rd_data, 64'h0F0E0D0C0B0A0908);

        // Write then read back on the next cycle.
        access(1'b1, 61'h2005, 64'hDEADBEEFCAFEF00D);
        access(1'b0, 61'h2005, '0);
        check("wr_rd_2005", rd_data, 64'hDEADBEEFCAFEF00D);

        // Out-of-range read below the base and write just past the top.
        access(1'b0, 61'h1FFF, '0);
        check("oor_rd_zero", rd_data, 64'd0);
        access(1'b1, BASE + 61'(64'd1 << DL), 64'h1234_5678_9ABC_DEF0);
        access(1'b0, 61'h2000, '0);
        check("oor_wr_dropped", rd_data, 64'h0706050403020100);
        check("oor_err_sticky", 64'(err), 64'd1);

        // Idle cycle: rd_data holds.
        @(negedge clk);
        @(negedge clk);
        check("idle_hold", rd_data, 64'h0706050403020100);

        // Short image with zero-filled upper lanes; reset here is taken from RUN.
        do_reset();
        img.delete();
        img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC);
        load_image(1'b0);
        access(1'b0, 61'h2000, '0);
        check("short_word0", rd_data, 64'h0000000000CCBBAA);

        // Reset in the middle of a load discards the partial word.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid = 1'b1;
            data  = 8'h55;
        end
        do_reset();
        img.delete();
        for (int i = 0; i < 8; i++) img.push_back(8'h11);
        load_image(1'b0);
        access(1'b0, 61'h2000, '0);
        check("midload_word0", rd_data, 64'h1111111111111111);

        // Randomized image with idle gaps, then random L1 traffic.
        do_reset();
        img.delete();
        n = $urandom_range(1, 48);
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
        load_image(1'b1);
        for (int t = 0; t < 80; t++) begin
            op = $urandom_range(0, 4);
            r64 = {$urandom, $urandom};
            case (op)
                0: access(1'b1, BASE + 61'($urandom_range(0, 7)), r64);
                1, 2: access(1'b0, BASE + 61'($urandom_range(0, 7)), '0);
                3: begin
                    case ($urandom_range(0, 2))
                        0: access(r64[0], BASE - 61'($urandom_range(1, 300)), r64);
                        1: access(r64[0], BASE + 61'(64'd1 << DL) + 61'($urandom_range(0, 300)), r64);
                        default: access(r64[0], r64[60:0], r64);
                    endcase
                end
                default: begin
                    @(negedge clk);
                    check("rand_idle_hold", rd_data, exp_rd);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
